// File: rtl/layer_sequencer.sv
// layer_sequencer
// Sequences one inference through a two-layer network. It starts each hidden
// neuron, streams the input indices to them, and waits for every hidden
// neuron to report. It then does the same for the output neurons, streaming
// the hidden activation indices, and finally pulses done.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   go                   start one inference (only looked at while idle)
//   abort                cancel the current inference, back to idle, no done
//   en                   step enable; low freezes state, counters and addresses
//   ready_ih[N_HID]      per-hidden-neuron result valid (looked at in IH_WAIT)
//   ready_ho[N_OUT]      per-output-neuron result valid (looked at in HO_WAIT)
//   start_ih/start_ho    one-hot single-cycle neuron start strobes
//   addr_in              input index, qualified by in_valid (IH_RUN)
//   addr_ih              hidden neuron being started (IH_START) or hidden
//                        activation index qualified by hid_valid (HO_RUN)
//   addr_ho              output neuron being started (HO_START)
//   busy, done, err      active; one-cycle completion; sticky timeout flag
//   dbg_state            current FSM state encoding
//
// Strobe semantics: start_ih, start_ho, in_valid, hid_valid and done are
// registered. Each one means that exactly one item is being issued this
// cycle. The consumer samples it on the next rising edge and has no way
// to back-pressure it. While en is low, these strobes are held at 0 and
// the sequencer does not advance. Because of that, every item is issued
// exactly once. An item that would have been issued during a stall is
// issued on the first enabled edge after en returns.
// Addresses hold during a stall and read 0 outside the states that own them.

module layer_sequencer #(
    parameter int N_IN  = 784,
    parameter int N_HID = 128,
    parameter int N_OUT = 10,
    parameter int AW    = 17,
    parameter int TMO   = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic             en,
    input  logic [N_HID-1:0] ready_ih,
    input  logic [N_OUT-1:0] ready_ho,
    output logic [N_HID-1:0] start_ih,
    output logic [N_OUT-1:0] start_ho,
    output logic [AW-1:0]    addr_in,
    output logic [AW-1:0]    addr_ih,
    output logic [AW-1:0]    addr_ho,
    output logic             in_valid,
    output logic             hid_valid,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IH_START = 3'd1,
        IH_RUN   = 3'd2,
        IH_WAIT  = 3'd3,
        HO_START = 3'd4,
        HO_RUN   = 3'd5,
        HO_WAIT  = 3'd6,
        DONE     = 3'd7
    } state_t;

    localparam logic [AW-1:0]    LAST_IN  = AW'(N_IN - 1);
    localparam logic [AW-1:0]    LAST_HID = AW'(N_HID - 1);
    localparam logic [AW-1:0]    LAST_OUT = AW'(N_OUT - 1);
    localparam logic [AW-1:0]    LAST_TMO = AW'(TMO - 1);
    localparam logic [N_HID-1:0] HID_ONE  = N_HID'(1);
    localparam logic [N_OUT-1:0] OUT_ONE  = N_OUT'(1);

    state_t        state;
    logic [AW-1:0] idx;      // position within the current START/RUN phase
    logic [AW-1:0] wait_cnt; // enabled cycles spent in the current WAIT state
    logic [AW-1:0] idx_nxt;

    assign idx_nxt   = idx + 1'b1;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state     <= IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            start_ih  <= '0;
            start_ho  <= '0;
            addr_in   <= '0;
            addr_ih   <= '0;
            addr_ho   <= '0;
            in_valid  <= 1'b0;
            hid_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else if (!en) begin
            // Freeze. Only the strobes are dropped, so the item shown
            // before the stall is not issued a second time.
            start_ih  <= '0;
            start_ho  <= '0;
            in_valid  <= 1'b0;
            hid_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            start_ih  <= '0;
            start_ho  <= '0;
            in_valid  <= 1'b0;
            hid_valid <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        state    <= IH_START;
                        idx      <= '0;
                        wait_cnt <= '0;
                        err      <= 1'b0;
                        busy     <= 1'b1;
                        start_ih <= HID_ONE;
                        addr_ih  <= '0;
                    end
                end
                IH_START: begin
                    if (idx == LAST_HID) begin
                        state    <= IH_RUN;
                        idx      <= '0;
                        addr_ih  <= '0;
                        addr_in  <= '0;
                        in_valid <= 1'b1;
                    end else begin
                        idx      <= idx_nxt;
                        addr_ih  <= idx_nxt;
                        start_ih <= HID_ONE << idx_nxt;
                    end
                end
                IH_RUN: begin
                    if (idx == LAST_IN) begin
                        state    <= IH_WAIT;
                        idx      <= '0;
                        wait_cnt <= '0;
                        addr_in  <= '0;
                    end else begin
                        idx      <= idx_nxt;
                        addr_in  <= idx_nxt;
                        in_valid <= 1'b1;
                    end
                end
                IH_WAIT: begin
                    // Ready is checked before the timeout, so a ready that
                    // arrives on the last allowed cycle wins.
                    if (&ready_ih) begin
                        state    <= HO_START;
                        idx      <= '0;
                        start_ho <= OUT_ONE;
                        addr_ho  <= '0;
                    end else if (wait_cnt == LAST_TMO) begin
                        state <= DONE;
                        err   <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HO_START: begin
                    if (idx == LAST_OUT) begin
                        state     <= HO_RUN;
                        idx       <= '0;
                        addr_ho   <= '0;
                        addr_ih   <= '0;
                        hid_valid <= 1'b1;
                    end else begin
                        idx      <= idx_nxt;
                        addr_ho  <= idx_nxt;
                        start_ho <= OUT_ONE << idx_nxt;
                    end
                end
                HO_RUN: begin
                    if (idx == LAST_HID) begin
                        state    <= HO_WAIT;
                        idx      <= '0;
                        wait_cnt <= '0;
                        addr_ih  <= '0;
                    end else begin
                        idx       <= idx_nxt;
                        addr_ih   <= idx_nxt;
                        hid_valid <= 1'b1;
                    end
                end
                HO_WAIT: begin
                    if (&ready_ho) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (wait_cnt == LAST_TMO) begin
                        state <= DONE;
                        err   <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer
// Directed bench for layer_sequencer with N_IN=4, N_HID=3, N_OUT=2, TMO=8.
// The reference model turns an accepted go into the ordered list of items
// one inference must issue: starts, indices, two waits, and done. On every
// enabled edge it consumes one item. Wait items are consumed when ready is
// complete or when the timeout runs out. The model's expected outputs are
// compared with the DUT on every falling edge. The directed sequences also
// pin specific cycles with hand-computed literals.
// "cycle n" is the n-th cycle shown after the edge that accepts go.

module tb_layer_sequencer;

    localparam int N_IN  = 4;
    localparam int N_HID = 3;
    localparam int N_OUT = 2;
    localparam int AW    = 8;
    localparam int TMO   = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go = 1'b0;
    logic abort = 1'b0;
    logic en = 1'b1;
    logic [N_HID-1:0] ready_ih = '1;
    logic [N_OUT-1:0] ready_ho = '1;

    logic [N_HID-1:0] start_ih;
    logic [N_OUT-1:0] start_ho;
    logic [AW-1:0]    addr_in, addr_ih, addr_ho;
    logic             in_valid, hid_valid, busy, done, err;
    logic [2:0]       dbg_state;

    always #5 clk = ~clk;

    layer_sequencer #(
        .N_IN(N_IN), .N_HID(N_HID), .N_OUT(N_OUT), .AW(AW), .TMO(TMO)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .en(en),
        .ready_ih(ready_ih), .ready_ho(ready_ho),
        .start_ih(start_ih), .start_ho(start_ho),
        .addr_in(addr_in), .addr_ih(addr_ih), .addr_ho(addr_ho),
        .in_valid(in_valid), .hid_valid(hid_valid),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Item kinds use the state numbering: 0 idle, 1 hidden start, 2 input
    // index, 3 hidden wait, 4 output start, 5 hidden index, 6 output wait,
    // 7 done.
    typedef struct {
        int kind;
        int idx;
    } beat_t;

    beat_t beats[$];
    beat_t cur = '{kind: 0, idx: 0};
    bit    live = 0;
    bit    strobe = 0;
    bit    m_err = 0;
    int    wcnt = 0;
    int    cyc = 0;

    task automatic build_inference();
        beats.delete();
        for (int k = 0; k < N_HID; k++) beats.push_back('{kind: 1, idx: k});
        for (int i = 0; i < N_IN; i++)  beats.push_back('{kind: 2, idx: i});
        beats.push_back('{kind: 3, idx: 0});
        for (int j = 0; j < N_OUT; j++) beats.push_back('{kind: 4, idx: j});
        for (int i = 0; i < N_HID; i++) beats.push_back('{kind: 5, idx: i});
        beats.push_back('{kind: 6, idx: 0});
        beats.push_back('{kind: 7, idx: 0});
    endtask

    task automatic advance();
        if (beats.size() == 0) cur = '{kind: 0, idx: 0};
        else cur = beats.pop_front();
        wcnt = 0;
    endtask

    always @(posedge clk) begin
        bit rdy;
        cyc++;
        if (rst || abort) begin
            if (rst) live = 1;
            beats.delete();
            cur = '{kind: 0, idx: 0};
            strobe = 0;
            m_err = 0;
            wcnt = 0;
        end else if (!en) begin
            strobe = 0;
        end else begin
            strobe = 1;
            if (cur.kind == 0) begin
                if (go) begin
                    build_inference();
                    m_err = 0;
                    advance();
                    cyc = 1;
                end
            end else if (cur.kind == 3 || cur.kind == 6) begin
                rdy = (cur.kind == 3) ? (&ready_ih) : (&ready_ho);
                if (rdy) begin
                    advance();
                end else if (wcnt == TMO - 1) begin
                    m_err = 1;
                    while (beats.size() > 0 && beats[0].kind != 7) beats.delete(0);
                    advance();
                end else begin
                    wcnt++;
                end
            end else begin
                advance();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic [31:0] e_sih, e_sho, e_ain, e_aih, e_aho;
        if (live) begin
            e_sih = (cur.kind == 1 && strobe) ? (32'd1 << cur.idx) : 32'd0;
            e_sho = (cur.kind == 4 && strobe) ? (32'd1 << cur.idx) : 32'd0;
            e_ain = (cur.kind == 2) ? cur.idx : 0;
            e_aih = (cur.kind == 1 || cur.kind == 5) ? cur.idx : 0;
            e_aho = (cur.kind == 4) ? cur.idx : 0;
            chk("start_ih", 32'(start_ih), e_sih);
            chk("start_ho", 32'(start_ho), e_sho);
            chk("addr_in", 32'(addr_in), e_ain);
            chk("addr_ih", 32'(addr_ih), e_aih);
            chk("addr_ho", 32'(addr_ho), e_aho);
            chk("in_valid", 32'(in_valid), 32'(cur.kind == 2 && strobe));
            chk("hid_valid", 32'(hid_valid), 32'(cur.kind == 5 && strobe));
            chk("done", 32'(done), 32'(cur.kind == 7 && strobe));
            chk("busy", 32'(busy), 32'(cur.kind != 0));
            chk("err", 32'(err), 32'(m_err));
            chk("state", 32'(dbg_state), 32'(cur.kind));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        int b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (cyc != n && b < 400);
        if (cyc != n) begin
            checks++;
            errors++;
            $display("FAIL wait_cyc actual=%0d required=%0d", cyc, n);
        end
    endtask

    // Called at a falling edge; returns at the falling edge of cycle 1.
    task automatic start_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        // Reset
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_addr_ih", 32'(addr_ih), 32'd0);
        chk("rst_start_ih", 32'(start_ih), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Nominal, with go raised while busy at cycle 3
        start_go();
        chk("nom_c1_start_ih", 32'(start_ih), 32'h1);
        wait_cyc(3);
        chk("nom_c3_start_ih", 32'(start_ih), 32'h4);
        go = 1'b1;
        wait_cyc(4);
        go = 1'b0;
        chk("nom_c4_in_valid", 32'(in_valid), 32'd1);
        wait_cyc(7);
        chk("nom_c7_addr_in", 32'(addr_in), 32'd3);
        wait_cyc(8);
        chk("nom_c8_state", 32'(dbg_state), 32'd3);
        wait_cyc(10);
        chk("nom_c10_start_ho", 32'(start_ho), 32'h2);
        wait_cyc(13);
        chk("nom_c13_addr_ih", 32'(addr_ih), 32'd2);
        wait_cyc(15);
        chk("nom_c15_done", 32'(done), 32'd1);
        wait_cyc(16);
        chk("nom_c16_busy", 32'(busy), 32'd0);

        // Output-layer timeout
        ready_ho = 2'b01;
        start_go();
        wait_cyc(21);
        chk("tmo_c21_state", 32'(dbg_state), 32'd6);
        wait_cyc(22);
        chk("tmo_c22_done", 32'(done), 32'd1);
        chk("tmo_c22_err", 32'(err), 32'd1);
        wait_cyc(24);
        chk("tmo_idle_err", 32'(err), 32'd1);
        ready_ho = 2'b11;
        start_go();
        chk("tmo_go_clears_err", 32'(err), 32'd0);
        wait_cyc(16);

        // Stall during IH_RUN
        start_go();
        wait_cyc(5);
        chk("stall_c5_addr_in", 32'(addr_in), 32'd1);
        en = 1'b0;
        wait_cyc(6);
        chk("stall_c6_addr_in", 32'(addr_in), 32'd1);
        chk("stall_c6_in_valid", 32'(in_valid), 32'd0);
        wait_cyc(8);
        en = 1'b1;
        wait_cyc(9);
        chk("stall_c9_addr_in", 32'(addr_in), 32'd2);
        wait_cyc(18);
        chk("stall_c18_done", 32'(done), 32'd1);
        wait_cyc(19);

        // Abort at cycle 10, then go+abort together in idle
        start_go();
        wait_cyc(10);
        abort = 1'b1;
        wait_cyc(11);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_start_ho", 32'(start_ho), 32'd0);
        go = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        go = 1'b0;
        abort = 1'b0;
        chk("go_abort_idle", 32'(busy), 32'd0);
        start_go();
        chk("abort_restart", 32'(start_ih), 32'h1);
        wait_cyc(16);

        // Reset mid-inference
        start_go();
        wait_cyc(6);
        rst = 1'b1;
        wait_cyc(7);
        rst = 1'b0;
        chk("rst_mid_addr_in", 32'(addr_in), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        start_go();
        chk("rst_restart", 32'(start_ih), 32'h1);
        wait_cyc(15);
        chk("rst_restart_done", 32'(done), 32'd1);
        wait_cyc(16);

        // Ready arrives on the last allowed IH_WAIT cycle: ready wins
        ready_ih = '0;
        start_go();
        wait_cyc(15);
        chk("rw_c15_state", 32'(dbg_state), 32'd3);
        ready_ih = '1;
        wait_cyc(16);
        chk("rw_c16_start_ho", 32'(start_ho), 32'h1);
        wait_cyc(22);
        chk("rw_c22_done", 32'(done), 32'd1);
        chk("rw_c22_err", 32'(err), 32'd0);
        wait_cyc(24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter N_IN, default 784: input vector length.
REQ-002 Parameter N_HID, default 128: hidden neuron count.
REQ-003 Parameter N_OUT, default 10: output neuron count.
REQ-004 Parameter AW, default 17: address and counter width; SHALL be able to hold max(N_IN, N_HID, N_OUT, TMO).
REQ-005 Parameter TMO, default 1024: wait-state timeout in enabled cycles.
REQ-006 clk  in  1  clock; all state changes on rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 go  in  1  start one inference; sampled in IDLE only.
REQ-009 abort  in  1  cancel the current inference.
REQ-010 en  in  1  step enable; low freezes the sequencer.
REQ-011 ready_ih  in  N_HID  per-hidden-neuron result valid.
REQ-012 ready_ho  in  N_OUT  per-output-neuron result valid.
REQ-013 start_ih  out  N_HID  one-hot single-cycle start to a hidden neuron.
REQ-014 start_ho  out  N_OUT  one-hot single-cycle start to an output neuron.
REQ-015 addr_in  out  AW  input index broadcast in IH_RUN.
REQ-016 addr_ih  out  AW  hidden index: neuron being started in IH_START; activation broadcast in HO_RUN.
REQ-017 addr_ho  out  AW  output neuron index during HO_START.
REQ-018 in_valid, hid_valid  out  1 each  addr_in / addr_ih broadcast valid.
REQ-019 busy, done, err  out  1 each  inference active; one-cycle completion pulse; sticky timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, IH_START, IH_RUN, IH_WAIT, HO_START, HO_RUN, HO_WAIT, DONE.
REQ-021 IDLE: go=1 -> IH_START; counters cleared; err cleared.
REQ-022 IH_START: start_ih bit k high for exactly one cycle, k = 0..N_HID-1 ascending, addr_ih=k; after k=N_HID-1 -> IH_RUN.
REQ-023 IH_RUN: addr_in = 0..N_IN-1, one per cycle, in_valid=1; after N_IN-1 -> IH_WAIT.
REQ-024 IH_WAIT: &ready_ih=1 -> HO_START; ready bits SHALL be ignored outside WAIT states.
REQ-025 HO_START: start_ho bit j high one cycle, j = 0..N_OUT-1, addr_ho=j; then -> HO_RUN.
REQ-026 HO_RUN: addr_ih = 0..N_HID-1, one per cycle, hid_valid=1; then -> HO_WAIT.
REQ-027 HO_WAIT: &ready_ho=1 -> DONE.
REQ-028 DONE: done=1 for one cycle; -> IDLE unconditionally.
REQ-029 busy SHALL be 1 in every state except IDLE.
REQ-030 Wait counter SHALL clear on WAIT entry, increment per en cycle in WAIT; reaching TMO with ready incomplete sets err=1 and -> DONE.
REQ-031 Ready complete on the same cycle the counter reaches TMO: ready wins, err stays 0.
REQ-032 en=0: state, counters and addresses hold; start_*, in_valid, hid_valid, done forced 0; suspended pulse reissues when en returns.
REQ-033 abort=1 (any state, any en): next state IDLE, all outputs to reset values, no done; abort has priority over go.
REQ-034 go while busy SHALL be ignored; go with abort in IDLE stays IDLE.
REQ-035 Counters SHALL never wrap; each phase terminates at its last index.
REQ-036 At most one start_ih or start_ho bit SHALL be high in any cycle.

Reset
REQ-037 rst=1 SHALL, at the next edge, force IDLE and all outputs 0 (addresses 0, start vectors 0, busy/done/err 0); rst has priority over abort, go and en.
REQ-038 rst mid-inference SHALL discard progress; next go restarts from IH_START index 0.

Verification (N_IN=4, N_HID=3, N_OUT=2, TMO=8, en=1, ready tied high unless stated; cycle n = n-th edge after go sampled)
REQ-039 Nominal: start_ih 001,010,100 cycles 1-3; addr_in 0..3 with in_valid cycles 4-7; IH_WAIT cycle 8; start_ho 01,10 cycles 9-10; addr_ih 0..2 with hid_valid cycles 11-13; HO_WAIT 14; done=1 cycle 15 only; busy 1-15.
REQ-040 Timeout: ready_ho=2'b01 held -> HO_WAIT 8 cycles, then DONE with err=1; err persists in IDLE, clears on next go.
REQ-041 Stall: en=0 for 3 cycles at cycle 5 (addr_in=1) -> addr_in holds 1, in_valid=0; resumes at 2; done at cycle 18.
REQ-042 Abort at cycle 10 -> cycle 11 IDLE, all outputs 0, no done; new go restarts with start_ih=001.
REQ-043 rst at cycle 6 -> outputs 0 next cycle; go asserted during busy (cycle 3) ignored, inference timing unchanged.
